// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry elastic pipeline register (main + skid slot).
// in_ready, out_valid, out_data and occupancy all come straight from flops,
// so a downstream stall never reaches the upstream producer combinationally.
module pipe_skid_buf #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding is {skid_v, main_v}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // State, both slots and every output register update together so that
  // in_ready/out_valid/occupancy always agree with the slot contents.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state     <= EMPTY;
      out_data  <= RESET_VAL;
      skid      <= RESET_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_data  <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: main is replaced, occupancy unchanged.
            out_data <= in_data;
          end else if (in_fire) begin
            // Downstream stalled while we accepted: park beat in skid.
            skid      <= in_data;
            state     <= TWO;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_fire) begin
            // out_data keeps the consumed value while empty.
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        TWO: begin
          // in_ready is low here, so in_valid is ignored.
          if (out_fire) begin
            out_data  <= skid;
            state     <= ONE;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_data  <= RESET_VAL;
          skid      <= RESET_VAL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_buf.md
# pipe_skid_buf

Two-entry elastic pipeline register with valid/ready handshakes on both sides. It sits between CPU pipeline stages and bus endpoints wherever a downstream stall must not combinationally reach the upstream producer. It is the consuming-side counterpart to the plain write-enabled flip-flop: data is captured on an upstream handshake and released on a downstream handshake. Full throughput is one beat per cycle, with registered `in_ready`.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `RESET_VAL`, default 0: value of `out_data` (and both internal slots) after reset or flush.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous, active-high; discards all buffered beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  buffer can accept a beat; driven straight from a flop.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  main slot holds a beat; driven straight from a flop.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  WIDTH  main-slot payload; driven straight from a flop.
- `occupancy`  out  2  beats held: 0, 1 or 2.

## Operation
- Storage:
  - main slot (`main`, `main_v`) drives the outputs.
  - skid slot (`skid`, `skid_v`) catches the beat accepted in the same cycle the downstream stalls.
- Handshakes:
  - in-fire = `in_valid & in_ready`.
  - out-fire = `out_valid & out_ready`.
- `in_ready` = !`skid_v`, registered. `out_ready` has no combinational path to `in_ready`.
- States, encoded by {`skid_v`, `main_v`}: EMPTY (00), ONE (01), TWO (11). 10 is illegal and never reached.
- EMPTY:
  - in-fire: `main` <= `in_data`, go to ONE.
  - otherwise: hold.
- ONE:
  - in-fire & out-fire: `main` <= `in_data`, stay ONE.
  - in-fire & !out-fire: `skid` <= `in_data`, go to TWO.
  - out-fire only: go to EMPTY.
  - otherwise: hold.
- TWO (`in_ready`=0, `in_valid` ignored):
  - out-fire: `main` <= `skid`, go to ONE.
  - otherwise: hold.
- Priority per cycle: `reset` > `flush` > handshakes.
- `flush`:
  - next state EMPTY; `main`, `skid` <= `RESET_VAL`.
  - An in-fire in the flush cycle is dropped.
  - An out-fire in the flush cycle still counts as consumed downstream; this block does nothing further with it.
- Data ordering is strictly FIFO. No beat is duplicated or lost except by flush or reset.
- `out_data` holds its last value while `out_valid`=0. It is `RESET_VAL` only after reset or flush.
- `in_data` is sampled only on in-fire.
- `occupancy` = `main_v` + `skid_v`, registered alongside the state.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=`RESET_VAL`, `occupancy`=0.
  - `in_ready`=1 from the first cycle after the reset edge.
- Latency: a beat in-fired at edge N appears on `out_valid`/`out_data` after edge N (usable in cycle N+1), provided it lands in `main`.
- Throughput:
  - one beat/cycle sustained while `out_ready`=1.
  - after a single stall cycle, the buffer absorbs exactly one extra beat.
- Stall response: `in_ready` falls one cycle after the first cycle with in-fire & !out-fire in ONE.
- Recovery: `in_ready` rises one cycle after the out-fire that drains TWO to ONE.
- Reset or flush asserted mid-transfer: takes effect at that edge; outputs match reset values the next cycle.
- `flush` and `reset` asserted together: identical result.

## Test plan
- Reset with `RESET_VAL`=0xDEAD: after one reset edge, `out_valid`=0, `out_data`=0xDEAD, `in_ready`=1, `occupancy`=0.
- Streaming with `out_ready`=1, inputs 1,2,3,4 on consecutive cycles: outputs 1,2,3,4 on consecutive cycles, one cycle later; `in_ready` stays 1; `occupancy` stays 1.
- Stall:
  - send 0xA then 0xB with `out_ready`=0: `occupancy`=2, `in_ready`=0; 0xC held on `in_data` is not taken.
  - raise `out_ready`: outputs 0xA, 0xB, then 0xC once `in_ready` returns; order is preserved.
- Flush in TWO holding 0x11, 0x22, with `in_valid`=1 and data 0x33 in the same cycle: next cycle `out_valid`=0, `occupancy`=0, `out_data`=`RESET_VAL`; 0x33 is never output.
- Random: random `in_valid`/`out_ready` over 10k cycles against a scoreboard.
  - No loss, duplication or reordering.
  - `in_ready`==!`skid_v` at all times.
  - `occupancy`≤2; state 10 never seen.
  - `out_data` stable while `out_valid` & !`out_ready`.
